// File: rtl/pipe_stage_regs.sv
`default_nettype none
// ============================================================================
// pipe_stage_regs : PC and F/D, D/E, E/M, M/W pipeline registers of the
//                   5-stage ARM core, with saturating stall/flush counters.
// Revision        : 1.0
// ============================================================================
module pipe_stage_regs #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic [PC_W-1:0]  PCNextF,
    input  logic [PC_W-1:0]  InstrF,
    output logic [PC_W-1:0]  PCF,
    output logic [PC_W-1:0]  InstrD,
    output logic             ValidD,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             MemWriteD,
    input  logic             PCSrcD,
    output logic [3:0]       RA1E,
    output logic [3:0]       RA2E,
    output logic [3:0]       WA3E,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic             MemWriteE,
    output logic             PCSrcE,
    output logic             ValidE,
    input  logic             CondExE,
    output logic [3:0]       WA3M,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemWriteM,
    output logic             PCSrcM,
    output logic             ValidM,
    output logic [3:0]       WA3W,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic             PCSrcW,
    output logic             ValidW,
    input  logic             CntClr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Fetch: PC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            PCF <= PCNextF;
        end
    end

    // F/D: stall has priority over flush so a held instruction is never lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD <= '0;
            ValidD <= 1'b0;
        end else if (StallD) begin
            InstrD <= InstrD;
            ValidD <= ValidD;
        end else if (FlushD) begin
            InstrD <= '0;
            ValidD <= 1'b0;
        end else begin
            InstrD <= InstrF;
            ValidD <= 1'b1;
        end
    end

    // D/E: control is qualified by ValidD so a decode bubble stays inert
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RA1E      <= '0;
            RA2E      <= '0;
            WA3E      <= '0;
            RegWriteE <= 1'b0;
            MemtoRegE <= 1'b0;
            MemWriteE <= 1'b0;
            PCSrcE    <= 1'b0;
            ValidE    <= 1'b0;
        end else if (FlushE) begin
            RA1E      <= '0;
            RA2E      <= '0;
            WA3E      <= '0;
            RegWriteE <= 1'b0;
            MemtoRegE <= 1'b0;
            MemWriteE <= 1'b0;
            PCSrcE    <= 1'b0;
            ValidE    <= 1'b0;
        end else begin
            RA1E      <= RA1D;
            RA2E      <= RA2D;
            WA3E      <= WA3D;
            RegWriteE <= RegWriteD & ValidD;
            MemtoRegE <= MemtoRegD & ValidD;
            MemWriteE <= MemWriteD & ValidD;
            PCSrcE    <= PCSrcD & ValidD;
            ValidE    <= ValidD;
        end
    end

    // E/M: side-effecting controls are cancelled when the condition fails
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WA3M      <= '0;
            RegWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            MemWriteM <= 1'b0;
            PCSrcM    <= 1'b0;
            ValidM    <= 1'b0;
        end else begin
            WA3M      <= WA3E;
            RegWriteM <= RegWriteE & CondExE;
            MemtoRegM <= MemtoRegE;
            MemWriteM <= MemWriteE & CondExE;
            PCSrcM    <= PCSrcE & CondExE;
            ValidM    <= ValidE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WA3W      <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
            ValidW    <= 1'b0;
        end else begin
            WA3W      <= WA3M;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            PCSrcW    <= PCSrcM;
            ValidW    <= ValidM;
        end
    end

    // Performance counters: clear wins over increment, saturate instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else if (CntClr) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF && (StallCnt != CNT_MAX)) begin
                StallCnt <= StallCnt + 1'b1;
            end
            if (FlushE && (FlushCnt != CNT_MAX)) begin
                FlushCnt <= FlushCnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_regs.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_regs : directed vector bench for pipe_stage_regs.
// Revision           : 1.0
// ============================================================================
module tb_pipe_stage_regs;

    localparam int              PC_W     = 32;
    localparam logic [31:0]     RESET_PC = 32'h0000_1000;
    localparam int              CNT_W    = 4;

    logic clk = 1'b0;
    logic reset;
    logic StallF, StallD, FlushD, FlushE, CntClr, CondExE;
    logic [31:0] PCNextF, InstrF, PCF, InstrD;
    logic ValidD;
    logic [3:0] RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic RegWriteD, MemtoRegD, MemWriteD, PCSrcD;
    logic RegWriteE, MemtoRegE, MemWriteE, PCSrcE, ValidE;
    logic RegWriteM, MemtoRegM, MemWriteM, PCSrcM, ValidM;
    logic RegWriteW, MemtoRegW, PCSrcW, ValidW;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_regs #(.PC_W(PC_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCNextF(PCNextF), .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .ValidD(ValidD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .PCSrcD(PCSrcD),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .PCSrcE(PCSrcE), .ValidE(ValidE), .CondExE(CondExE),
        .WA3M(WA3M), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .PCSrcM(PCSrcM), .ValidM(ValidM),
        .WA3W(WA3W), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
        .ValidW(ValidW),
        .CntClr(CntClr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    typedef struct {
        logic        stallf, stalld, flushd, flushe, cntclr, condex;
        logic [31:0] pcnext, instr;
        logic [3:0]  ra1, ra2, wa3;
        logic        rw, m2r, mw, pcsrc;
    } in_t;

    typedef struct {
        logic [31:0] pcf, instrd;
        logic        validd;
        logic [3:0]  ra1e, ra2e, wa3e;
        logic        rwe, mwe, pcsrce, valide;
        logic [3:0]  wa3m;
        logic        rwm, m2rm, mwm, pcsrcm, validm;
        logic [3:0]  wa3w;
        logic        rww, m2rw, pcsrcw, validw;
        logic [3:0]  scnt, fcnt;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] pack_exp(input exp_t e);
        return {e.pcf, e.instrd, e.validd, e.ra1e, e.ra2e, e.wa3e,
                e.rwe, e.mwe, e.pcsrce, e.valide,
                e.wa3m, e.rwm, e.m2rm, e.mwm, e.pcsrcm, e.validm,
                e.wa3w, e.rww, e.m2rw, e.pcsrcw, e.validw, e.scnt, e.fcnt};
    endfunction

    function automatic logic [127:0] pack_act();
        return {PCF, InstrD, ValidD, RA1E, RA2E, WA3E,
                RegWriteE, MemWriteE, PCSrcE, ValidE,
                WA3M, RegWriteM, MemtoRegM, MemWriteM, PCSrcM, ValidM,
                WA3W, RegWriteW, MemtoRegW, PCSrcW, ValidW, StallCnt, FlushCnt};
    endfunction

    task automatic apply(input in_t v);
        StallF = v.stallf; StallD = v.stalld; FlushD = v.flushd; FlushE = v.flushe;
        CntClr = v.cntclr; CondExE = v.condex; PCNextF = v.pcnext; InstrF = v.instr;
        RA1D = v.ra1; RA2D = v.ra2; WA3D = v.wa3;
        RegWriteD = v.rw; MemtoRegD = v.m2r; MemWriteD = v.mw; PCSrcD = v.pcsrc;
    endtask

    task automatic idle();
        apply('{0,0,0,0,0,1, 32'h0, 32'h0, 4'd0,4'd0,4'd0, 0,0,0,0});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bits that must all be zero while the pipeline is held in reset
    function automatic logic [31:0] reset_bits();
        return {InstrD, 1'b0} | {31'd0, ValidD | ValidE | ValidM | ValidW |
                RegWriteE | MemWriteE | PCSrcE | MemtoRegE | RegWriteM | MemWriteM |
                PCSrcM | MemtoRegM | RegWriteW | PCSrcW | MemtoRegW |
                (|WA3E) | (|WA3M) | (|WA3W) | (|StallCnt) | (|FlushCnt)};
    endfunction

    initial begin
        vecs[0] = '{'{0,0,0,0,0,1, 32'h1004, 32'hE0810002, 4'd1,4'd2,4'd3,  1,0,0,0},
                    '{32'h1004, 32'hE0810002, 1, 4'd1,4'd2,4'd3,  0,0,0,0, 4'd0, 0,0,0,0,0, 4'd0, 0,0,0,0, 4'd0,4'd0}};
        vecs[1] = '{'{0,0,0,0,0,1, 32'h1008, 32'hE0842005, 4'd4,4'd5,4'd2,  1,1,0,0},
                    '{32'h1008, 32'hE0842005, 1, 4'd4,4'd5,4'd2,  1,0,0,1, 4'd3, 0,0,0,0,0, 4'd0, 0,0,0,0, 4'd0,4'd0}};
        vecs[2] = '{'{0,0,0,0,0,1, 32'h100C, 32'hE5801000, 4'd0,4'd1,4'd7,  0,0,1,0},
                    '{32'h100C, 32'hE5801000, 1, 4'd0,4'd1,4'd7,  0,1,0,1, 4'd2, 1,1,0,0,1, 4'd3, 0,0,0,0, 4'd0,4'd0}};
        vecs[3] = '{'{0,0,0,0,0,0, 32'h1010, 32'hEA000001, 4'd8,4'd9,4'd10, 1,0,1,1},
                    '{32'h1010, 32'hEA000001, 1, 4'd8,4'd9,4'd10, 1,1,1,1, 4'd7, 0,0,0,0,1, 4'd2, 1,1,0,1, 4'd0,4'd0}};
        vecs[4] = '{'{1,1,0,1,0,0, 32'h2000, 32'h12345678, 4'd3,4'd4,4'd5,  1,0,0,0},
                    '{32'h1010, 32'hEA000001, 1, 4'd0,4'd0,4'd0,  0,0,0,0, 4'd10, 0,0,0,0,1, 4'd7, 0,0,0,1, 4'd1,4'd1}};
        vecs[5] = '{'{0,0,0,0,0,1, 32'h1014, 32'hE2800001, 4'd0,4'd0,4'd6,  1,0,0,0},
                    '{32'h1014, 32'hE2800001, 1, 4'd0,4'd0,4'd6,  1,0,0,1, 4'd0, 0,0,0,0,0, 4'd10, 0,0,0,1, 4'd1,4'd1}};
        vecs[6] = '{'{0,0,1,0,0,1, 32'h1020, 32'hDEADBEEF, 4'd1,4'd1,4'd9,  0,0,0,1},
                    '{32'h1020, 32'h0, 0, 4'd1,4'd1,4'd9,  0,0,1,1, 4'd6, 1,0,0,0,1, 4'd0, 0,0,0,0, 4'd1,4'd1}};
        vecs[7] = '{'{0,0,0,0,0,1, 32'h1024, 32'hE3A0100A, 4'd2,4'd3,4'd11, 1,0,0,0},
                    '{32'h1024, 32'hE3A0100A, 1, 4'd2,4'd3,4'd11, 0,0,0,0, 4'd9, 0,0,0,1,1, 4'd6, 1,0,0,1, 4'd1,4'd1}};
        vecs[8] = '{'{0,1,1,0,0,1, 32'h1028, 32'h11111111, 4'd4,4'd4,4'd12, 1,0,0,0},
                    '{32'h1028, 32'hE3A0100A, 1, 4'd4,4'd4,4'd12, 1,0,0,1, 4'd11, 0,0,0,0,0, 4'd9, 0,0,1,1, 4'd1,4'd1}};
        vecs[9] = '{'{1,0,0,0,1,1, 32'h2222, 32'h22222222, 4'd5,4'd6,4'd13, 0,1,0,0},
                    '{32'h1028, 32'h22222222, 1, 4'd5,4'd6,4'd13, 0,0,0,1, 4'd12, 1,0,0,0,1, 4'd11, 0,0,0,0, 4'd0,4'd0}};

        // Power-on reset
        reset = 1'b1;
        idle();
        #2;
        check("reset_pcf", {96'd0, PCF}, {96'd0, RESET_PC});
        check("reset_zero", {96'd0, reset_bits()}, 128'd0);
        step();
        @(negedge clk);
        reset = 1'b0;
        #1;

        for (int n = 0; n < 10; n++) begin
            apply(vecs[n].i);
            step();
            check($sformatf("vec%0d", n), pack_act(), pack_exp(vecs[n].e));
        end

        // Stall counter saturates at 15 with CNT_W=4; clear beats a same-cycle increment
        idle();
        StallF = 1'b1;
        for (int n = 0; n < 20; n++) step();
        check("stall_sat", {124'd0, StallCnt}, 128'd15);
        CntClr = 1'b1;
        step();
        check("stall_clr", {124'd0, StallCnt}, 128'd0);

        idle();
        FlushE = 1'b1;
        for (int n = 0; n < 3; n++) step();
        check("flush_cnt3", {124'd0, FlushCnt}, 128'd3);
        check("flush_valide", {127'd0, ValidE}, 128'd0);

        // Fill the pipeline, then reset asynchronously between edges
        idle();
        PCNextF = 32'h3000; InstrF = 32'hE1A00000; WA3D = 4'd5; RegWriteD = 1'b1;
        StallF = 1'b1;
        for (int n = 0; n < 4; n++) step();
        check("fill_valid", {124'd0, ValidD, ValidE, ValidM, ValidW}, 128'hF);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_pcf", {96'd0, PCF}, {96'd0, RESET_PC});
        check("midrst_zero", {96'd0, reset_bits()}, 128'd0);
        step();
        @(negedge clk);
        reset = 1'b0;
        StallF = 1'b0;
        #1;
        check("rel_hold", {PCF, 31'd0, ValidD, 64'd0}, {RESET_PC, 31'd0, 1'b0, 64'd0});
        step();
        check("rel_edge", {PCF, InstrD, 61'd0, ValidD, ValidE, ValidM}, {32'h3000, 32'hE1A00000, 61'd0, 1'b1, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
